// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter driven by a 16x baud tick
module uart_tx_buffered #(
  parameter int PAYLOAD_SIZE = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_TICKS   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic [PAYLOAD_SIZE-1:0] i_data,
  input  logic                    i_wr,
  output logic                    o_tx,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = (PAYLOAD_SIZE > 1) ? $clog2(PAYLOAD_SIZE) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [PAYLOAD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0] st, st_n;
  logic [3:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [PAYLOAD_SIZE-1:0] b, b_n;
  logic done_n, tx_n, wr_ok, pop;
  assign o_full  = cnt == (AW+1)'(FIFO_DEPTH);
  assign o_empty = cnt == '0;
  assign o_busy  = st != IDLE;
  assign wr_ok   = i_wr & ~o_full;
  assign pop     = (st == IDLE) & ~o_empty;
  always_comb begin
    st_n   = st;
    s_n    = s;
    n_n    = n;
    b_n    = b;
    done_n = 1'b0;
    if (pop) begin
      st_n = START;
      s_n  = 4'd0;
      b_n  = mem[rp];
    end else if (i_tick && st != IDLE) begin
      s_n = s + 4'd1;
      if (st == START && s == 4'd15) begin
        s_n  = 4'd0;
        n_n  = '0;
        st_n = DATA;
      end else if (st == DATA && s == 4'd15) begin
        s_n  = 4'd0;
        b_n  = b >> 1;
        st_n = (n == NW'(PAYLOAD_SIZE-1)) ? STOP : DATA;
        n_n  = (n == NW'(PAYLOAD_SIZE-1)) ? n : n + 1'b1;
      end else if (st == STOP && s == 4'(STOP_TICKS-1)) begin
        st_n   = IDLE;
        done_n = 1'b1;
      end
    end
    // line level is computed from the next state so o_tx can be a plain flop
    tx_n = (st_n == START) ? 1'b0 : (st_n == DATA) ? b_n[0] : 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wp] <= i_data;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      st     <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      o_tx   <= 1'b1;
      o_done <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (wr_ok && !pop) cnt <= cnt + 1'b1;
      else if (pop && !wr_ok) cnt <= cnt - 1'b1;
      st     <= st_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      o_tx   <= tx_n;
      o_done <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed stimulus with a line-decoding scoreboard monitor
module tb_uart_tx_buffered;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic tx, full, empty, busy, done;
  int errors = 0, checks = 0, done_cnt = 0, tc = 0, mc = 0, base = 0;
  logic act = 1'b0, ptx = 1'b1, idle_ok = 1'b1;
  logic [7:0] sh = 8'h00;
  logic [7:0] exp_q [$];

  uart_tx_buffered dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_data(data), .i_wr(wr),
    .o_tx(tx), .o_full(full), .o_empty(empty), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tc = (tc + 1) % 4;
    tick = (tc == 0);
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // decodes each frame at bit centres (64 clocks per bit) and pops the expected byte
  initial forever begin
    @(negedge clk);
    if (rst) begin
      act = 1'b0;
      ptx = 1'b1;
    end else begin
      if (done) done_cnt++;
      if (!act) begin
        if (ptx && !tx) begin act = 1'b1; mc = 0; end
      end else begin
        mc++;
        if (mc == 32) chk("start_bit", tx, 0);
        else if (mc > 32 && mc <= 32 + 64*8 && (mc - 32) % 64 == 0) sh = {tx, sh[7:1]};
        else if (mc == 32 + 64*9) begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected no frame", sh);
          end else chk("frame_data", sh, exp_q.pop_front());
          act = 1'b0;
        end
      end
      ptx = tx;
    end
  end

  task automatic put(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1;
    data = d;
    exp_q.push_back(d);
  endtask

  task automatic wait_done_pulse(input int budget, input string nm);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_cnt(input int target, input int budget, input string nm);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    chk(nm, done_cnt >= target, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // single frame 0xA5
    put(8'hA5);
    @(negedge clk);
    wr = 1'b0;
    chk("lat_empty_after_wr", empty, 0);
    chk("lat_tx_still_idle", tx, 1);
    chk("lat_busy_low", busy, 0);
    @(negedge clk);
    chk("lat_tx_fall", tx, 0);
    chk("lat_busy_rise", busy, 1);
    chk("lat_empty_after_pop", empty, 1);
    wait_done_pulse(800, "single_done");
    chk("single_busy_low", busy, 0);
    @(negedge clk);
    chk("single_done_one_cycle", done, 0);
    chk("single_empty", empty, 1);
    // overflow: six writes, the sixth is dropped
    base = done_cnt;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("ovf_not_full_yet", full, 0);
      if (i == 6) chk("ovf_full_after_5", full, 1);
      wr = 1'b1;
      data = 8'(i);
      if (i <= 5) exp_q.push_back(8'(i));
    end
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_still_full", full, 1);
    wait_cnt(base + 5, 4000, "ovf_five_frames");
    repeat (700) @(negedge clk);
    chk("ovf_done_count", done_cnt - base, 5);
    chk("ovf_empty", empty, 1);
    chk("ovf_queue_drained", exp_q.size(), 0);
    // back-to-back 0x00 then 0xFF
    put(8'h00);
    put(8'hFF);
    @(negedge clk);
    wr = 1'b0;
    wait_done_pulse(800, "b2b_first_done");
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_tx", tx, 1);
    @(negedge clk);
    chk("b2b_next_start_tx", tx, 0);
    chk("b2b_next_busy", busy, 1);
    chk("b2b_done_dropped", done, 0);
    wait_done_pulse(800, "b2b_second_done");
    @(negedge clk);
    chk("b2b_empty", empty, 1);
    // simultaneous write and pop with one byte queued
    put(8'h11);
    put(8'h22);
    @(negedge clk);
    wr = 1'b0;
    wait_done_pulse(800, "sim_first_done");
    wr = 1'b1;
    data = 8'h33;
    exp_q.push_back(8'h33);
    @(negedge clk);
    wr = 1'b0;
    chk("sim_not_empty", empty, 0);
    chk("sim_not_full", full, 0);
    chk("sim_busy", busy, 1);
    base = done_cnt;
    wait_cnt(base + 2, 1600, "sim_two_frames");
    repeat (5) @(negedge clk);
    chk("sim_empty", empty, 1);
    chk("sim_queue_drained", exp_q.size(), 0);
    // mid-frame asynchronous reset during data bit 3 of 0x5A
    put(8'h5A);
    put(8'h33);
    @(negedge clk);
    wr = 1'b0;
    repeat (64*4 + 20) @(negedge clk);
    chk("mid_tx_in_bit3", tx, 1);
    base = done_cnt;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    chk("mid_line_idle", idle_ok, 1);
    chk("mid_no_done", done_cnt - base, 0);
    chk("mid_empty", empty, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: the send-side counterpart of the existing receiver, driven by the same 16x-oversampling tick from the baud tick generator. Bytes written by the host (CPU/debug unit) are queued in a small FIFO and serialized 8N1, LSB first, with no host stalls while a frame is in flight. It sits between the host write port and the `o_tx` pin in the UART top level.

## Interface
- `PAYLOAD_SIZE`, 8: data bits per frame.
- `FIFO_DEPTH`, 4: queued bytes; power of two, ≥2.
- `STOP_TICKS`, 16: stop-bit length in ticks (16 = one stop bit).
- `i_clk` input 1: system clock; only clock.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_tick` input 1: 16x baud tick, high for exactly one `i_clk` cycle.
- `i_data` input PAYLOAD_SIZE: byte to queue.
- `i_wr` input 1: write strobe; `i_data` is sampled on any cycle where this is high.
- `o_tx` output 1: serial line; idle high.
- `o_full` output 1: FIFO holds FIFO_DEPTH entries.
- `o_empty` output 1: FIFO holds 0 entries.
- `o_busy` output 1: high in any state other than IDLE.
- `o_done` output 1: one-cycle pulse at the end of each frame's stop bit.

## Operation
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth, plus a count of log2(FIFO_DEPTH)+1 bits. `o_full`/`o_empty` are decoded from the registered count.
- Write is accepted when `i_wr`=1 and `o_full`=0, using the count before that edge. A write while full is dropped, even if a pop occurs on the same edge. Nothing else records the dropped byte.
- Simultaneous accepted write and pop: the count is unchanged and both pointers advance.
- FSM states are IDLE, START, DATA and STOP. It uses a 4-bit tick counter `s`, a bit index `n`, and a shift register `b`.
  - IDLE: `o_tx`=1. If `o_empty`=0, on the next edge pop the head into `b`, clear `s`, and go to START. This transition does not wait for `i_tick`.
  - START: `o_tx`=0. On each tick `s`++. On the tick where `s`=15, clear `s` and `n`, then go to DATA.
  - DATA: `o_tx`=`b[0]`. On each tick `s`++. On the tick where `s`=15, clear `s` and shift `b` right. If `n`=PAYLOAD_SIZE-1, go to STOP; otherwise increment `n`.
  - STOP: `o_tx`=1. On each tick `s`++. On the tick where `s`=STOP_TICKS-1, assert `o_done` for one cycle and go to IDLE.
- Cycles without a tick hold all FSM registers.
- `o_tx` is registered, so the line has no glitches.

## Timing
- Reset values: `o_tx`=1, `o_full`=0, `o_empty`=1, `o_busy`=0, `o_done`=0. FIFO pointers, count, `s`, `n` and `b` are all 0, and the FSM is in IDLE.
- Latency from a write into an empty, idle FIFO:
  - Write accepted at edge k.
  - `o_empty`=0 after edge k.
  - Pop at edge k+1; `o_tx` falls and `o_busy` rises after edge k+1.
- Each bit lasts exactly 16 ticks, with the start bit counted from the first tick after entering START. The frame is 16·(1+PAYLOAD_SIZE) + STOP_TICKS ticks, plus up to one tick period of phase slack at the start.
- Back-to-back frames: `o_done` is asserted at the STOP exit edge, IDLE lasts exactly one cycle, and the next START begins the following cycle. No extra idle bit is inserted.
- `o_full`/`o_empty` reflect the write/pop of edge k immediately after edge k.
- Asynchronous reset mid-frame: `o_tx` goes to 1 immediately without waiting for a clock. The FIFO is flushed, the frame is aborted, and no `o_done` is issued.

## Test plan
- Reset check: assert `i_rst` for 3 cycles with no clock edge required -> `o_tx`=1, `o_empty`=1, `o_full`=0, `o_busy`=0, `o_done`=0.
- Single frame: `i_tick` every 4th clock; write 0xA5 -> `o_tx` (one bit = 64 clocks) shows 0, 1,0,1,0,0,1,0,1, then 1 after 16 stop ticks; `o_done` pulses once; `o_busy` falls; `o_empty`=1.
- Overflow: write 0x01..0x06 on six consecutive cycles while idle -> 0x01 is popped at edge 1 and `o_full`=1 after edge 4. The 0x06 write is dropped. Frames 0x01..0x05 go out in order, giving exactly five `o_done` pulses.
- Back-to-back: queue 0x00 and 0xFF -> exactly one IDLE cycle between the end of the first stop bit and the second start bit; line patterns are all-zero data then all-one data.
- Simultaneous write and pop with count=1 -> count stays 1, and both bytes are sent in write order.
- Mid-frame reset: assert `i_rst` during DATA bit 3 of 0x5A with 0x33 queued -> `o_tx`=1 immediately and no `o_done`. After release, no frame is sent until a new write arrives (`o_empty`=1).
